// File: rtl/fp_link_master_pkg.sv
// rtl/fp_link_master_pkg.sv - shared types and constants for the front-panel link master
// Contents:
//   link_state_e      : master FSM states
//   HDR_WRITE/HDR_READ: header bit values sent in the first bit cell
//   PLAY..IDLE        : front-panel command bytes
//   HALF_W/GAP_W      : counter widths sized for the SCK_HALF/GAP_CYC maxima (1023/4095)
package fp_link_master_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_WDATA,
        ST_RDATA,
        ST_GAP
    } link_state_e;

    localparam logic HDR_WRITE = 1'b0;
    localparam logic HDR_READ  = 1'b1;

    localparam logic [7:0] PLAY   = 8'h80;
    localparam logic [7:0] STOP   = 8'h60;
    localparam logic [7:0] REWIND = 8'h20;
    localparam logic [7:0] FF     = 8'h40;
    localparam logic [7:0] IDLE   = 8'h08;

    localparam int HALF_W = 10;
    localparam int GAP_W  = 12;

endpackage

// File: rtl/fp_link_master_if.sv
// rtl/fp_link_master_if.sv - command/status handshake and serial pins of the link master
// Signals:
//   cmd_valid/cmd_data/cmd_ready : command byte handshake
//   stat_req                     : level request for a status read
//   stat_valid/stat_data         : status byte result
//   busy                         : master not in IDLE
//   SCK/SDATA_OUT/SDATA_OE       : serial clock and data driven by the master
//   SDATA_IN                     : shared data line as seen by the master
// Modports: master (the link master), slave (the user/drive side).
interface fp_link_master_if;

    logic       cmd_valid;
    logic [7:0] cmd_data;
    logic       cmd_ready;
    logic       stat_req;
    logic       stat_valid;
    logic [7:0] stat_data;
    logic       busy;
    logic       SCK;
    logic       SDATA_OUT;
    logic       SDATA_OE;
    logic       SDATA_IN;

    modport master (
        input  cmd_valid, cmd_data, stat_req, SDATA_IN,
        output cmd_ready, stat_valid, stat_data, busy, SCK, SDATA_OUT, SDATA_OE
    );

    modport slave (
        output cmd_valid, cmd_data, stat_req, SDATA_IN,
        input  cmd_ready, stat_valid, stat_data, busy, SCK, SDATA_OUT, SDATA_OE
    );

endinterface

// File: rtl/fp_sck_gen.sv
// rtl/fp_sck_gen.sv - SCK half-period and bit-cell timer
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   run        : high while a bit cell is in progress; low parks the timer at the
//                start of a high phase
//   fall_stb   : SCK must fall on the next clock edge
//   rise_stb   : SCK must rise on the next clock edge
//   cell_done  : the current bit cell ends on the next clock edge
module fp_sck_gen import fp_link_master_pkg::*; #(
    parameter int SCK_HALF = 100
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic fall_stb,
    output logic rise_stb,
    output logic cell_done
);

    localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(SCK_HALF - 1);

    logic [HALF_W-1:0] half_cnt;
    logic              low_phase;
    logic              half_end;

    assign half_end  = run && (half_cnt == HALF_LAST);
    assign fall_stb  = half_end && !low_phase;
    assign rise_stb  = half_end && low_phase;
    // A cell always finishes with the return of SCK to high.
    assign cell_done = rise_stb;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            half_cnt  <= '0;
            low_phase <= 1'b0;
        end else if (!run) begin
            half_cnt  <= '0;
            low_phase <= 1'b0;
        end else if (half_cnt == HALF_LAST) begin
            half_cnt  <= '0;
            low_phase <= !low_phase;
        end else begin
            half_cnt <= half_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/fp_link_master.sv
// rtl/fp_link_master.sv - front-panel serial link master (header bit + 8 data bits)
// Ports:
//   PI_CLK   : system clock, rising edge
//   RESET_n  : asynchronous active-low reset
//   bus      : fp_link_master_if.master (command/status handshake and serial pins)
// Each transaction is 9 bit cells (header + 8 data bits) followed by GAP_CYC
// cycles of SCK-high idle. Writes shift out the latched command byte; reads
// turn the line around after the header fall and shift in a status byte.
module fp_link_master import fp_link_master_pkg::*; #(
    parameter int SCK_HALF = 100,
    parameter int GAP_CYC  = 400
) (
    input  logic               PI_CLK,
    input  logic               RESET_n,
    fp_link_master_if.master   bus
);

    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);

    link_state_e      state;
    logic             cmd_ready_q;
    logic             busy_q;
    logic             sck_q;
    logic             sdo_q;
    logic             oe_q;
    logic             stat_valid_q;
    logic [7:0]       stat_data_q;
    logic [7:0]       shreg;
    logic [2:0]       bit_cnt;
    logic [GAP_W-1:0] gap_cnt;
    logic             hdr_bit;

    logic run;
    logic fall_stb;
    logic rise_stb;
    logic cell_done;

    assign run = (state == ST_HDR) || (state == ST_WDATA) || (state == ST_RDATA);

    fp_sck_gen #(
        .SCK_HALF (SCK_HALF)
    ) u_sck_gen (
        .clk       (PI_CLK),
        .rst_n     (RESET_n),
        .run       (run),
        .fall_stb  (fall_stb),
        .rise_stb  (rise_stb),
        .cell_done (cell_done)
    );

    assign bus.cmd_ready  = cmd_ready_q;
    assign bus.busy       = busy_q;
    assign bus.SCK        = sck_q;
    assign bus.SDATA_OUT  = sdo_q;
    assign bus.SDATA_OE   = oe_q;
    assign bus.stat_valid = stat_valid_q;
    assign bus.stat_data  = stat_data_q;

    always_ff @(posedge PI_CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            state        <= ST_IDLE;
            cmd_ready_q  <= 1'b0;
            busy_q       <= 1'b0;
            sck_q        <= 1'b1;
            sdo_q        <= 1'b0;
            oe_q         <= 1'b0;
            stat_valid_q <= 1'b0;
            stat_data_q  <= 8'h00;
            shreg        <= 8'h00;
            bit_cnt      <= 3'd0;
            gap_cnt      <= '0;
            hdr_bit      <= HDR_WRITE;
        end else begin
            stat_valid_q <= 1'b0;
            if (fall_stb) sck_q <= 1'b0;
            if (rise_stb) sck_q <= 1'b1;

            case (state)
                ST_IDLE: begin
                    cmd_ready_q <= 1'b1;
                    // Gating on cmd_ready_q keeps the first cycle after reset
                    // release from accepting anything.
                    if (cmd_ready_q && bus.cmd_valid) begin
                        state       <= ST_HDR;
                        cmd_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        hdr_bit     <= HDR_WRITE;
                        shreg       <= bus.cmd_data;
                        oe_q        <= 1'b1;
                        sdo_q       <= HDR_WRITE;
                    end else if (cmd_ready_q && bus.stat_req) begin
                        state       <= ST_HDR;
                        cmd_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        hdr_bit     <= HDR_READ;
                        oe_q        <= 1'b1;
                        sdo_q       <= HDR_READ;
                    end
                end

                ST_HDR: begin
                    // Release the line as the drive samples the read header,
                    // so it can start driving data in the low phase.
                    if (fall_stb && hdr_bit == HDR_READ) oe_q <= 1'b0;
                    if (cell_done) begin
                        bit_cnt <= 3'd0;
                        if (hdr_bit == HDR_READ) begin
                            state <= ST_RDATA;
                        end else begin
                            state <= ST_WDATA;
                            sdo_q <= shreg[7];
                            shreg <= {shreg[6:0], 1'b0};
                        end
                    end
                end

                ST_WDATA: begin
                    if (cell_done) begin
                        if (bit_cnt == 3'd7) begin
                            state   <= ST_GAP;
                            gap_cnt <= '0;
                            oe_q    <= 1'b0;
                            sdo_q   <= 1'b0;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                            sdo_q   <= shreg[7];
                            shreg   <= {shreg[6:0], 1'b0};
                        end
                    end
                end

                ST_RDATA: begin
                    if (cell_done) begin
                        shreg <= {shreg[6:0], bus.SDATA_IN};
                        if (bit_cnt == 3'd7) begin
                            stat_data_q  <= {shreg[6:0], bus.SDATA_IN};
                            stat_valid_q <= 1'b1;
                            state        <= ST_GAP;
                            gap_cnt      <= '0;
                            sdo_q        <= 1'b0;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end
                end

                ST_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state       <= ST_IDLE;
                        busy_q      <= 1'b0;
                        cmd_ready_q <= 1'b1;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_link_master.sv
// tb/tb_fp_link_master.sv - directed-vector bench for fp_link_master (SCK_HALF=4, GAP_CYC=8)
module tb_fp_link_master;
    import fp_link_master_pkg::*;

    logic PI_CLK;
    logic RESET_n;
    fp_link_master_if bus();

    fp_link_master #(
        .SCK_HALF (4),
        .GAP_CYC  (8)
    ) dut (
        .PI_CLK  (PI_CLK),
        .RESET_n (RESET_n),
        .bus     (bus)
    );

    initial PI_CLK = 1'b0;
    always #5 PI_CLK = ~PI_CLK;

    int n_vec  = 0;
    int n_miss = 0;

    logic [7:0] drv_byte = 8'h00;

    logic prev_sck  = 1'b1;
    logic prev_busy = 1'b0;
    int   hi_run    = 0;
    int   lo_run    = 0;
    int   last_lo   = 0;
    int   txn_falls = 0;
    int   sv_cnt    = 0;
    logic fall_sdo[$];
    logic fall_oe[$];
    int   fall_hi[$];
    int   txn_q[$];

    // Line monitor and drive model, sampled on the falling clock edge.
    // The drive presents status bit 7..0 after SCK falls 2..9 of a transaction.
    always @(negedge PI_CLK) begin
        if (prev_sck === 1'b1 && bus.SCK === 1'b0) begin
            fall_sdo.push_back(bus.SDATA_OUT);
            fall_oe.push_back(bus.SDATA_OE);
            fall_hi.push_back(hi_run);
            txn_falls++;
            if (txn_falls >= 2 && txn_falls <= 9) bus.SDATA_IN = drv_byte[3'(9 - txn_falls)];
        end
        if (txn_falls == 0) bus.SDATA_IN = 1'b0;
        if (bus.SCK === 1'b1) hi_run++; else hi_run = 0;
        if (prev_busy === 1'b1 && bus.busy === 1'b0) begin
            txn_q.push_back(txn_falls);
            txn_falls = 0;
        end
        if (RESET_n) begin
            if (bus.cmd_ready === 1'b0) lo_run++;
            else if (lo_run != 0) begin
                last_lo = lo_run;
                lo_run  = 0;
            end
        end
        if (bus.stat_valid === 1'b1) sv_cnt++;
        prev_sck  = bus.SCK;
        prev_busy = bus.busy;
    end

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge PI_CLK);
            #1;
        end
    endtask

    task automatic wait_busy(input string tag, input logic lvl);
        for (int i = 0; i < 400 && bus.busy !== lvl; i++) tick(1);
        if (bus.busy !== lvl) check_vec({tag, "_busy_timeout"}, 32'(bus.busy), 32'(lvl));
    endtask

    task automatic wait_falls(input string tag, input int base, input int n);
        for (int i = 0; i < 400 && (fall_sdo.size() - base) < n; i++) tick(1);
        if ((fall_sdo.size() - base) < n) check_vec({tag, "_fall_timeout"}, 32'(fall_sdo.size() - base), 32'(n));
    endtask

    task automatic send_cmd(input logic [7:0] b);
        bus.cmd_valid = 1'b1;
        bus.cmd_data  = b;
        for (int i = 0; i < 400 && bus.cmd_ready !== 1'b1; i++) tick(1);
        if (bus.cmd_ready !== 1'b1) check_vec("send_timeout", 32'(bus.cmd_ready), 32'd1);
        tick(1);
        bus.cmd_valid = 1'b0;
    endtask

    // Nine recorded fall samples, first fall in the MSB position; X where missing.
    function automatic logic [31:0] pack9(input int start, input bit use_oe);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 9; i++) begin
            if (start + i < fall_sdo.size())
                r = {r[30:0], use_oe ? fall_oe[start + i] : fall_sdo[start + i]};
            else
                r = {r[30:0], 1'bx};
        end
        return r;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int base;
        int tbase;
        int sv0;

        RESET_n       = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_data  = 8'h00;
        bus.stat_req  = 1'b0;
        tick(3);

        check_vec("rst_sck",        32'(bus.SCK),        32'd1);
        check_vec("rst_oe",         32'(bus.SDATA_OE),   32'd0);
        check_vec("rst_sdo",        32'(bus.SDATA_OUT),  32'd0);
        check_vec("rst_stat_valid", 32'(bus.stat_valid), 32'd0);
        check_vec("rst_stat_data",  32'(bus.stat_data),  32'h00);
        check_vec("rst_busy",       32'(bus.busy),       32'd0);
        check_vec("rst_cmd_ready",  32'(bus.cmd_ready),  32'd0);

        RESET_n = 1'b1;
        tick(1);
        check_vec("rel_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check_vec("rel_busy",      32'(bus.busy),      32'd0);
        tick(2);

        // Write PLAY
        base  = fall_sdo.size();
        tbase = txn_q.size();
        send_cmd(PLAY);
        wait_busy("play", 1'b0);
        tick(2);
        check_vec("play_bits",      pack9(base, 1'b0),            32'h080);
        check_vec("play_oe",        pack9(base, 1'b1),            32'h1FF);
        check_vec("play_falls",     32'(fall_sdo.size() - base),  32'd9);
        check_vec("play_ready_low", 32'(last_lo),                 32'd80);
        check_vec("play_idle_oe",   32'(bus.SDATA_OE),            32'd0);
        check_vec("play_idle_sck",  32'(bus.SCK),                 32'd1);

        // Status read returning A5
        drv_byte = 8'hA5;
        base     = fall_sdo.size();
        sv0      = sv_cnt;
        bus.stat_req = 1'b1;
        wait_busy("rd", 1'b1);
        bus.stat_req = 1'b0;
        wait_busy("rd", 1'b0);
        tick(2);
        check_vec("rd_data",  32'(bus.stat_data),           32'hA5);
        check_vec("rd_pulse", 32'(sv_cnt - sv0),            32'd1);
        check_vec("rd_falls", 32'(fall_sdo.size() - base),  32'd9);
        check_vec("rd_oe",    pack9(base, 1'b1),            32'h000);
        check_vec("rd_hdr",   32'(fall_sdo[base]),          32'd1);

        // Command and status request in the same cycle
        drv_byte = 8'h3C;
        base     = fall_sdo.size();
        sv0      = sv_cnt;
        bus.stat_req = 1'b1;
        send_cmd(STOP);
        wait_falls("simul", base, 10);
        bus.stat_req = 1'b0;
        wait_busy("simul", 1'b0);
        tick(2);
        check_vec("simul_wbits", pack9(base, 1'b0),           32'h060);
        check_vec("simul_rhdr",  pack9(base + 9, 1'b0) >> 8,  32'd1);
        check_vec("simul_data",  32'(bus.stat_data),          32'h3C);
        check_vec("simul_pulse", 32'(sv_cnt - sv0),           32'd1);
        check_vec("simul_falls", 32'(fall_sdo.size() - base), 32'd18);
        if (fall_hi.size() > base + 9)
            check_vec("simul_gap", 32'(fall_hi[base + 9] >= 8), 32'd1);
        else
            check_vec("simul_gap_missing", 32'(fall_hi.size() - base), 32'd10);

        // Back-to-back REWIND then FF
        base  = fall_sdo.size();
        tbase = txn_q.size();
        send_cmd(REWIND);
        send_cmd(FF);
        wait_busy("b2b", 1'b0);
        tick(2);
        check_vec("b2b_bits1", pack9(base, 1'b0),           32'h020);
        check_vec("b2b_bits2", pack9(base + 9, 1'b0),       32'h040);
        check_vec("b2b_falls", 32'(fall_sdo.size() - base), 32'd18);
        check_vec("b2b_ntxn",  32'(txn_q.size() - tbase),   32'd2);
        if (txn_q.size() >= tbase + 2) begin
            check_vec("b2b_txn1_falls", 32'(txn_q[tbase]),     32'd9);
            check_vec("b2b_txn2_falls", 32'(txn_q[tbase + 1]), 32'd9);
        end
        if (fall_hi.size() > base + 9)
            check_vec("b2b_gap", 32'(fall_hi[base + 9] >= 8), 32'd1);

        // cmd_data changes while the byte is in flight
        base = fall_sdo.size();
        send_cmd(IDLE);
        bus.cmd_data = 8'hF7;
        tick(20);
        bus.cmd_data = 8'h55;
        wait_busy("chg", 1'b0);
        tick(2);
        check_vec("chg_bits",  pack9(base, 1'b0),           32'h008);
        check_vec("chg_falls", 32'(fall_sdo.size() - base), 32'd9);

        // Reset in the middle of a status read
        drv_byte = 8'hFF;
        base     = fall_sdo.size();
        bus.stat_req = 1'b1;
        wait_busy("mid", 1'b1);
        bus.stat_req = 1'b0;
        wait_falls("mid", base, 5);
        sv0 = sv_cnt;
        check_vec("mid_pre_sck", 32'(bus.SCK), 32'd0);
        RESET_n = 1'b0;
        #2;
        check_vec("mid_sck",        32'(bus.SCK),        32'd1);
        check_vec("mid_oe",         32'(bus.SDATA_OE),   32'd0);
        check_vec("mid_sdo",        32'(bus.SDATA_OUT),  32'd0);
        check_vec("mid_busy",       32'(bus.busy),       32'd0);
        check_vec("mid_cmd_ready",  32'(bus.cmd_ready),  32'd0);
        check_vec("mid_stat_data",  32'(bus.stat_data),  32'h00);
        tick(2);
        RESET_n = 1'b1;
        tick(1);
        check_vec("mid_rel_ready", 32'(bus.cmd_ready), 32'd1);
        tick(150);
        check_vec("mid_no_pulse", 32'(sv_cnt - sv0),           32'd0);
        check_vec("mid_falls",    32'(fall_sdo.size() - base), 32'd5);
        check_vec("mid_data",     32'(bus.stat_data),          32'h00);
        check_vec("mid_idle",     32'(bus.busy),               32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
